// File: rtl/spi_mstr16.sv
// rtl/spi_mstr16.sv - 16-bit full-duplex SPI master (SCLK idles high, MOSI changes on SCLK fall)
module spi_mstr16 #(
    parameter int                DIV_W   = 5,
    parameter logic [DIV_W-1:0]  FP_LOAD = 5'b10111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    localparam logic [DIV_W-1:0] DIV_ALL1 = '1;
    localparam logic [DIV_W-1:0] DIV_HALF = {1'b0, {(DIV_W-1){1'b1}}};

    state_t           state, nxt_state;
    logic [DIV_W-1:0] div;
    logic [4:0]       bit_cnt;
    logic [15:0]      shft_reg;
    logic             miso_smpl;

    logic rise_pt, fall_pt;
    logic ld, smpl, shift, set_done, div_en;

    // The divider value one step before SCLK edges; the edge lands on the next clk.
    assign rise_pt = (div == DIV_HALF);
    assign fall_pt = (div == DIV_ALL1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (wrt)                         nxt_state = FRONT;
            FRONT:   if (fall_pt)                     nxt_state = SHIFT;
            SHIFT:   if (rise_pt && bit_cnt == 5'd15) nxt_state = BACK;
            BACK:    if (fall_pt)                     nxt_state = IDLE;
            default:                                  nxt_state = IDLE;
        endcase
    end

    always_comb begin
        SS_n     = 1'b0;
        ld       = 1'b0;
        smpl     = 1'b0;
        shift    = 1'b0;
        set_done = 1'b0;
        div_en   = 1'b1;
        case (state)
            IDLE: begin
                SS_n   = 1'b1;
                div_en = 1'b0;
                ld     = wrt;
            end
            FRONT: ;
            SHIFT: begin
                smpl  = rise_pt;
                shift = fall_pt;
            end
            BACK: begin
                // Final shift happens on the would-be wrap; the divider then parks at all-ones.
                shift    = fall_pt;
                set_done = fall_pt;
                div_en   = !fall_pt;
            end
            default: begin
                SS_n   = 1'b1;
                div_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= DIV_ALL1;
            bit_cnt   <= 5'd0;
            shft_reg  <= 16'h0000;
            miso_smpl <= 1'b0;
            done      <= 1'b0;
        end else if (ld) begin
            div      <= FP_LOAD;
            bit_cnt  <= 5'd0;
            shft_reg <= wt_data;
            done     <= 1'b0;
        end else begin
            if (div_en) begin
                div <= div + 1'b1;
            end
            if (smpl) begin
                miso_smpl <= MISO;
                bit_cnt   <= bit_cnt + 5'd1;
            end
            if (shift) begin
                shft_reg <= {shft_reg[14:0], miso_smpl};
            end
            if (set_done) begin
                done <= 1'b1;
            end
        end
    end

    assign SCLK    = div[DIV_W-1];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

endmodule

// File: tb/tb_spi_mstr16.sv
// tb/tb_spi_mstr16.sv - self-checking bench for spi_mstr16 with frame-timing model and SPI slave
module tb_spi_mstr16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] wt_data = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int checks = 0;
    int errors = 0;

    logic        loop = 1'b1;
    logic [15:0] slave_tx = 16'h0000;
    logic [15:0] s_tx = 16'h0000;
    logic [15:0] s_rx = 16'h0000;
    int          s_cnt = 0;
    logic        sclk_q = 1'b1;
    logic        ss_q = 1'b1;

    logic        m_valid = 1'b0;
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic        m_rd_known = 1'b0;
    logic [15:0] m_rd = 16'h0000;
    logic [15:0] m_tx = 16'h0000;
    logic [15:0] m_rx = 16'h0000;
    int          n = 0;

    spi_mstr16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always #5 clk = ~clk;

    assign MISO = loop ? MOSI : s_tx[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame timeline counted in clk edges after the accepting edge E0.
    function automatic logic exp_sclk(input int k);
        if (k < 9 || k >= 521) return 1'b1;
        return 1'(((k - 9) / 16) % 2);
    endfunction

    function automatic int mosi_bit(input int k);
        int j;
        if (k < 41) j = 0;
        else        j = (k - 41) / 32 + 1;
        if (j > 15) j = 15;
        return 15 - j;
    endfunction

    // Mode-3 slave: samples MOSI on SCLK rise, presents next bit after the rise.
    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            s_tx = slave_tx;
        end else if (ss_q === 1'b1) begin
            s_cnt = 0;
        end else if (SCLK === 1'b1 && sclk_q === 1'b0) begin
            s_rx  = {s_rx[14:0], MOSI};
            s_tx  = s_tx << 1;
            s_cnt = s_cnt + 1;
        end
        sclk_q = SCLK;
        ss_q   = SS_n;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active   = 1'b0;
            m_done     = 1'b0;
            m_rd       = 16'h0000;
            m_rd_known = 1'b1;
            m_valid    = 1'b1;
        end else if (m_active) begin
            n = n + 1;
            if (n == 521) begin
                m_active   = 1'b0;
                m_done     = 1'b1;
                m_rd       = m_rx;
                m_rd_known = 1'b1;
            end
        end else if (wrt) begin
            m_active   = 1'b1;
            n          = 0;
            m_tx       = wt_data;
            m_rx       = loop ? wt_data : slave_tx;
            m_done     = 1'b0;
            m_rd_known = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ss_n", {15'd0, SS_n}, {15'd0, !m_active});
            check("sclk", {15'd0, SCLK}, {15'd0, m_active ? exp_sclk(n) : 1'b1});
            check("done", {15'd0, done}, {15'd0, m_done});
            if (m_active) check("mosi", {15'd0, MOSI}, {15'd0, m_tx[mosi_bit(n)]});
            if (m_rd_known) check("rd_data", rd_data, m_rd);
        end
    end

    task automatic start(input logic [15:0] d);
        wrt     = 1'b1;
        wt_data = d;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=%b expected 1 within 2000 clk", done);
        end
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wrt     = 1'(i % 2);
            wt_data = 16'hFFFF;
            @(negedge clk);
        end
        wrt = 1'b0;
        check("rst_ss_n", {15'd0, SS_n}, 16'd1);
        check("rst_sclk", {15'd0, SCLK}, 16'd1);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_rd",   rd_data, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        loop = 1'b1;
        start(16'hA5C3);
        wait_done(1, c);
        check("lb_latency", 16'(c), 16'd522);
        check("lb_rd",      rd_data, 16'hA5C3);
        check("lb_rises",   16'(s_cnt), 16'd16);
        check("lb_mosi",    s_rx, 16'hA5C3);
        @(negedge clk);

        loop     = 1'b0;
        slave_tx = 16'h0FF0;
        @(negedge clk);
        start(16'hD000);
        repeat (99) @(negedge clk);
        wrt     = 1'b1;
        wt_data = 16'h5555;
        @(negedge clk);
        wrt = 1'b0;
        wait_done(101, c);
        check("sl_latency", 16'(c), 16'd522);
        check("sl_rd",      rd_data, 16'h0FF0);
        check("sl_mosi",    s_rx, 16'hD000);
        check("sl_rises",   16'(s_cnt), 16'd16);
        @(negedge clk);

        loop = 1'b1;
        start(16'h3C5A);
        repeat (299) @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n", {15'd0, SS_n}, 16'd1);
        check("mid_rst_sclk", {15'd0, SCLK}, 16'd1);
        check("mid_rst_done", {15'd0, done}, 16'd0);
        check("mid_rst_rd",   rd_data, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(16'h96E1);
        wait_done(1, c);
        check("post_rst_latency", 16'(c), 16'd522);
        check("post_rst_rd",      rd_data, 16'h96E1);
        @(negedge clk);

        start(16'h1234);
        wait_done(1, c);
        check("b2b_a_latency", 16'(c), 16'd522);
        check("b2b_a_rd",      rd_data, 16'h1234);
        check("b2b_gap_ss_n",  {15'd0, SS_n}, 16'd1);
        start(16'hFEDC);
        check("b2b_done_clr",  {15'd0, done}, 16'd0);
        check("b2b_b_ss_n",    {15'd0, SS_n}, 16'd0);
        wait_done(1, c);
        check("b2b_b_latency", 16'(c), 16'd522);
        check("b2b_b_rd",      rd_data, 16'hFEDC);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
